// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: streams two WIDTH-bit operands LSB-first through one
// full adder cell built from two half adders, with a registered carry.

module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module full_adder_from_half (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    logic s1;
    logic c1;
    logic c2;

    half_adder u_ha0 (.x(x),  .y(y),  .s(s1), .c(c1));
    half_adder u_ha1 (.x(s1), .y(ci), .s(s),  .c(c2));

    assign co = c1 | c2;
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_nxt;
    logic             cy;
    logic [CW-1:0]    cnt;

    logic fa_s;
    logic fa_c;
    logic last;
    logic load;
    logic step;
    logic fin;

    full_adder_from_half u_fa (
        .x  (sa[0]),
        .y  (sb[0]),
        .ci (cy),
        .s  (fa_s),
        .co (fa_c)
    );

    assign last = (cnt == CW'(WIDTH - 1));

    // Next result image: current bit enters at the MSB end.
    generate
        if (WIDTH == 1) begin : g_one
            assign sr_nxt = fa_s;
        end else begin : g_many
            assign sr_nxt = {fa_s, sr[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN:  if (last)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        load = 1'b0;
        step = 1'b0;
        fin  = 1'b0;
        unique case (state_q)
            IDLE: load = start;
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                fin  = last;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa  <= '0;
            sb  <= '0;
            sr  <= '0;
            cy  <= 1'b0;
            cnt <= '0;
        end else if (load) begin
            sa  <= a;
            sb  <= b;
            cy  <= cin;
            cnt <= '0;
        end else if (step) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            sr  <= sr_nxt;
            cy  <= fa_c;
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= fin;
            if (fin) begin
                sum  <= sr_nxt;
                cout <= fa_c;
            end
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: stimulus pushes expected
// results, a negedge monitor pops them on every done pulse.

module tb_serial_adder_ctrl;
    localparam int W = 8;
    localparam int BOUND = 4 * W + 10;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    typedef struct packed {
        logic [W:0]  res;
        logic [31:0] acc;
    } exp_t;

    exp_t       q[$];
    logic [W:0] held;
    int         cyc;
    int         checks;
    int         errors;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: checks results, latency and output holding.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (done) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done got=%h at cyc %0d",
                             {cout, sum}, cyc);
                end else begin
                    e = q.pop_front();
                    if ({cout, sum} !== e.res) begin
                        errors++;
                        $display("FAIL result got=%h exp=%h",
                                 {cout, sum}, e.res);
                    end
                    checks++;
                    if (cyc !== int'(e.acc) + W) begin
                        errors++;
                        $display("FAIL latency got=%0d exp=%0d",
                                 cyc - int'(e.acc), W);
                    end
                    held = e.res;
                end
            end else if (busy) begin
                checks++;
                if ({cout, sum} !== held) begin
                    errors++;
                    $display("FAIL hold got=%h exp=%h", {cout, sum}, held);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic go(input logic [W-1:0] xa, input logic [W-1:0] xb,
                      input logic xc, input logic [W:0] res);
        @(posedge clk);
        #1;
        start = 1'b1;
        a = xa;
        b = xb;
        cin = xc;
        q.push_back('{res: res, acc: 32'(cyc + 1)});
        @(posedge clk);
        #1;
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        cin = 1'($urandom);
        chk("busy_after_accept", 32'(busy), 32'd1);
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < BOUND && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL timeout got=no_done exp=done");
        end
    endtask

    initial begin
        cyc = 0;
        checks = 0;
        errors = 0;
        held = '0;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;

        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            start = 1'($urandom);
            a = W'($urandom);
            b = W'($urandom);
            cin = 1'($urandom);
            #1;
            chk("reset_outs", 32'({busy, done, cout, sum}), 32'd0);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_after_release", 32'({busy, done}), 32'd0);

        go(8'h5A, 8'h33, 1'b0, 9'h08D);
        wait_done();
        go(8'hFF, 8'h01, 1'b0, 9'h100);
        wait_done();
        go(8'hFF, 8'hFF, 1'b1, 9'h1FF);
        wait_done();

        // Start while busy must be ignored.
        go(8'h10, 8'h20, 1'b0, 9'h030);
        @(posedge clk);
        #1;
        start = 1'b1;
        a = 8'hAA;
        b = 8'h55;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done();

        // Start in the done cycle is accepted.
        start = 1'b1;
        a = 8'h01;
        b = 8'h02;
        cin = 1'b1;
        q.push_back('{res: 9'h004, acc: 32'(cyc + 1)});
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_b2b", 32'(busy), 32'd1);
        wait_done();

        // Start held high: back-to-back with one idle cycle.
        @(posedge clk);
        #1;
        start = 1'b1;
        a = 8'h80;
        b = 8'h80;
        cin = 1'b0;
        q.push_back('{res: 9'h100, acc: 32'(cyc + 1)});
        q.push_back('{res: 9'h100, acc: 32'(cyc + 2 + W)});
        wait_done();
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done();

        // Reset mid-operation.
        go(8'hF0, 8'h0F, 1'b0, 9'h0FF);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midreset_outs", 32'({busy, done, cout, sum}), 32'd0);
        q.delete();
        held = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (W + 2) @(posedge clk);
        #1;
        chk("no_done_after_reset", 32'({busy, cout, sum}), 32'd0);
        go(8'hF0, 8'h0F, 1'b0, 9'h0FF);
        wait_done();

        repeat (W + 2) @(posedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
